// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring unsigned divider, fixed WIDTH-cycle latency.
// Start/busy/done handshake, optional auto-trigger on operand change, divide-by-zero flag.
module seq_divider #(
    parameter int unsigned WIDTH = 32,
    parameter bit          AUTO  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int unsigned      CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, ZERO} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;    // stored partial remainder is always < divisor
    logic [WIDTH-1:0] shift_q;  // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] last_dividend_q;
    logic [WIDTH-1:0] last_divisor_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic             accept;
    logic [WIDTH:0]   rem_shift;
    logic             q_bit;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        accept    = start || (AUTO && ((dividend != last_dividend_q) ||
                                       (divisor  != last_divisor_q)));
        rem_shift = {rem_q, shift_q[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, dvs_q});
        rem_d     = q_bit ? WIDTH'(rem_shift - {1'b0, dvs_q}) : rem_shift[WIDTH-1:0];
        shift_d   = {shift_q[WIDTH-2:0], q_bit};
    end

    // NOTE: every register is cleared by the async reset so an abort leaves no stale result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            rem_q           <= '0;
            shift_q         <= '0;
            dvs_q           <= '0;
            last_dividend_q <= '0;
            last_divisor_q  <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            dbz_q           <= 1'b0;
            quotient_q      <= '0;
            remainder_q     <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees the pre-edge state.
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q         <= dividend;
                        dvs_q           <= divisor;
                        last_dividend_q <= dividend;
                        last_divisor_q  <= divisor;
                        rem_q           <= '0;
                        cnt_q           <= '0;
                        busy_q          <= 1'b1;
                        state_q         <= (divisor == '0) ? ZERO : CALC;
                    end
                end
                CALC: begin
                    rem_q   <= rem_d;
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        quotient_q  <= shift_d;
                        remainder_q <= rem_d;
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                ZERO: begin
                    quotient_q  <= '1;
                    remainder_q <= shift_q;
                    dbz_q       <= 1'b1;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
